alu_mul_seq: RTL

Multi-cycle unsigned multiplier controller that sequences the shared N-bit `alu` datapath to form a 2N-bit product by shift-and-add. It uses one ALU ADD per multiplier bit. It sits beside the `alu` instance in the lab designs: it owns the ALU's operand and control inputs for the duration of a multiply, and the board top level drives it from switches and shows the product on the HEX displays. Handshake: single-cycle start pulse in, single-cycle done pulse out, with the result held until the next start.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_mul_seq_if.sv | 23 ++
 rtl/alu.sv | 32 +++
 rtl/alu_mul_seq.sv | 96 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the multiplier sequencer state type.
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Start/operand/result handshake between a requester and the multiply sequencer.
interface alu_mul_seq_if #(parameter int N = 4);

    logic             i_start;
    logic [N-1:0]     i_a;
    logic [N-1:0]     i_b;
    logic             o_ready;
    logic             o_busy;
    logic             o_done;
    logic [2*N-1:0]   o_product;
    logic [1:0]       o_alu_ctrl;

    modport master (
        output i_start, i_a, i_b,
        input  o_ready, o_busy, o_done, o_product, o_alu_ctrl
    );

    modport slave (
        input  i_start, i_a, i_b,
        output o_ready, o_busy, o_done, o_product, o_alu_ctrl
    );

endinterface

// File: rtl/alu.sv
// N-bit combinational ALU: add, subtract (carry = no borrow), and, or.
module alu
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [1:0]   i_alu_ctrl,
    output logic [N-1:0] o_result,
    output logic         o_carry
);

    localparam int W = N + 1;

    logic [W-1:0] wide;

    always_comb begin
        wide = '0;
        case (i_alu_ctrl)
            ALU_ADD: wide = {1'b0, i_a} + {1'b0, i_b};
            ALU_SUB: wide = {1'b0, i_a} + {1'b0, ~i_b} + W'(1);
            ALU_AND: wide = {1'b0, i_a & i_b};
            ALU_OR:  wide = {1'b0, i_a | i_b};
            default: wide = '0;
        endcase
    end

    assign o_result = wide[N-1:0];
    assign o_carry  = wide[N];

endmodule

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier that drives the shared ALU with one ADD per multiplier bit.
//   state  | meaning
//   S_IDLE | ready; an i_start captures operands
//   S_RUN  | one add+shift per cycle, N cycles
//   S_DONE | product registered, o_done pulses for one cycle
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    alu_mul_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    mul_state_t       state_q, state_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     p_q, p_d;
    logic [N-1:0]     q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]   product_q, product_d;

    logic [N-1:0]     alu_b;
    logic [N-1:0]     sum;
    logic             carry;

    assign alu_b = q_q[0] ? a_q : '0;

    alu #(.N(N)) u_alu (
        .i_a        (p_q),
        .i_b        (alu_b),
        .i_alu_ctrl (ALU_ADD),
        .o_result   (sum),
        .o_carry    (carry)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        p_d       = p_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    a_d     = bus.i_a;
                    q_d     = bus.i_b;
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // the N+1-bit sum shifts right into {p,q}, so the carry lands in p's MSB
                p_d   = {carry, sum[N-1:1]};
                q_d   = {sum[0], q_q[N-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    product_d = {carry, sum, q_q[N-1:1]};
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            p_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            p_q       <= p_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus.o_ready    = (state_q == S_IDLE);
    assign bus.o_busy     = (state_q == S_RUN) || (state_q == S_DONE);
    assign bus.o_done     = (state_q == S_DONE);
    assign bus.o_product  = product_q;
    assign bus.o_alu_ctrl = ALU_ADD;

endmodule
